// File: rtl/dfdd_pkg.sv
// Shared definitions for the DFDD pipeline front end: FP16 field layout,
// raster coordinate width and the input formatter state encoding.
package dfdd_pkg;

  localparam int EXP_WIDTH   = 5;
  localparam int FRAC_WIDTH  = 10;
  localparam int EXP_BIAS    = 15;
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  localparam int COORD_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLUS,
    ST_MINUS,
    ST_FLUSH
  } fmt_state_e;

endpackage

// File: rtl/uint_to_fp16.sv
// Two-stage unsigned integer to FP16 converter with a delayed sideband.
// DFDD_INPUT_NORMALIZE_EN scales the result by 2^-PIXEL_WIDTH into [0,1).
module uint_to_fp16
  import dfdd_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int SIDE_WIDTH  = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic [PIXEL_WIDTH-1:0] value_i,
  input  logic [SIDE_WIDTH-1:0]  side_i,
  output logic                   valid_o,
  output logic [15:0]            fp16_o,
  output logic [SIDE_WIDTH-1:0]  side_o
);

  localparam int MSB_W = 4;
`ifdef DFDD_INPUT_NORMALIZE_EN
  localparam int NORM_SHIFT = PIXEL_WIDTH;
`else
  localparam int NORM_SHIFT = 0;
`endif
  localparam logic [EXP_WIDTH-1:0] EXP_BASE = EXP_WIDTH'(EXP_BIAS - NORM_SHIFT);

  logic                   s1_valid_q, s1_valid_d;
  logic [PIXEL_WIDTH-1:0] s1_value_q, s1_value_d;
  logic [MSB_W-1:0]       s1_msb_q,   s1_msb_d;
  logic [SIDE_WIDTH-1:0]  s1_side_q,  s1_side_d;
  logic                   valid_q,    valid_d;
  logic [15:0]            fp16_q,     fp16_d;
  logic [SIDE_WIDTH-1:0]  side_q,     side_d;

  logic [FRAC_WIDTH:0]    ext;
  logic [FRAC_WIDTH-1:0]  frac;
  logic [EXP_WIDTH-1:0]   exp_field;

  // Stage 1: leading-one position, registered alongside the raw value.
  always_comb begin
    s1_valid_d = valid_i;
    s1_value_d = value_i;
    s1_side_d  = side_i;
    s1_msb_d   = '0;
    for (int i = 0; i < PIXEL_WIDTH; i++) begin
      if (value_i[i]) s1_msb_d = MSB_W'(i);
    end
  end

  // Stage 2: align the leading one to the hidden bit and pack; results hold between strobes.
  always_comb begin
    ext       = (FRAC_WIDTH + 1)'(s1_value_q);
    frac      = FRAC_WIDTH'(ext << (MSB_W'(FRAC_WIDTH) - s1_msb_q));
    exp_field = EXP_BASE + EXP_WIDTH'(s1_msb_q);
    valid_d   = s1_valid_q;
    fp16_d    = fp16_q;
    side_d    = side_q;
    if (s1_valid_q) begin
      fp16_d = (s1_value_q == '0) ? FP16_ZERO : {1'b0, exp_field, frac};
      side_d = s1_side_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_value_q <= '0;
      s1_msb_q   <= '0;
      s1_side_q  <= '0;
      valid_q    <= 1'b0;
      fp16_q     <= FP16_ZERO;
      side_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_value_q <= s1_value_d;
      s1_msb_q   <= s1_msb_d;
      s1_side_q  <= s1_side_d;
      valid_q    <= valid_d;
      fp16_q     <= fp16_d;
      side_q     <= side_d;
    end
  end

  assign valid_o = valid_q;
  assign fp16_o  = fp16_q;
  assign side_o  = side_q;

endmodule

// File: rtl/dfdd_input_formatter.sv
// DFDD input stage: pairs interleaved rho-plus/rho-minus beats, converts them
// to FP16 and tags each pair with raster col/row. Build option: DFDD_INPUT_NORMALIZE_EN.
module dfdd_input_formatter
  import dfdd_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int PIXEL_WIDTH  = 8,
  parameter int FLUSH_CYCLES = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [PIXEL_WIDTH-1:0] pixel_i,
  input  logic                   pixel_valid_i,
  output logic                   pixel_ready_o,
  input  logic                   sof_i,
  output logic [15:0]            i_rho_plus_o,
  output logic [15:0]            i_rho_minus_o,
  output logic [15:0]            col_o,
  output logic [15:0]            row_o,
  output logic                   valid_o,
  output logic                   frame_done_o,
  output logic                   error_o
);

  localparam logic [COORD_WIDTH-1:0] COL_MAX = COORD_WIDTH'(IMAGE_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] ROW_MAX = COORD_WIDTH'(IMAGE_HEIGHT - 1);
  localparam logic [31:0]            FLUSH_LOAD = 32'(FLUSH_CYCLES - 1);

  fmt_state_e             state_q, state_d;
  logic                   ready_q, ready_d;
  logic                   error_q, error_d;
  logic [PIXEL_WIDTH-1:0] plus_hold_q, plus_hold_d;
  logic [COORD_WIDTH-1:0] col_q, col_d, row_q, row_d;
  logic [31:0]            flush_cnt_q, flush_cnt_d;
  logic                   pair_valid_q, pair_valid_d;
  logic                   pair_last_q, pair_last_d;
  logic [PIXEL_WIDTH-1:0] pair_plus_q, pair_plus_d, pair_minus_q, pair_minus_d;
  logic [COORD_WIDTH-1:0] pair_col_q, pair_col_d, pair_row_q, pair_row_d;

  logic                   accept;
  logic                   last_pos;
  logic                   plus_valid, minus_valid;
  logic [COORD_WIDTH:0]   plus_side;

  assign accept   = pixel_valid_i && ready_q;
  assign last_pos = (col_q == COL_MAX) && (row_q == ROW_MAX);

  // Ready is registered from the next state so it stays low throughout reset.
  always_comb begin
    state_d      = state_q;
    error_d      = error_q;
    plus_hold_d  = plus_hold_q;
    col_d        = col_q;
    row_d        = row_q;
    flush_cnt_d  = flush_cnt_q;
    pair_valid_d = 1'b0;
    pair_last_d  = pair_last_q;
    pair_plus_d  = pair_plus_q;
    pair_minus_d = pair_minus_q;
    pair_col_d   = pair_col_q;
    pair_row_d   = pair_row_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && sof_i) begin
          plus_hold_d = pixel_i;
          col_d       = '0;
          row_d       = '0;
          state_d     = ST_MINUS;
        end
      end
      ST_PLUS: begin
        if (accept) begin
          plus_hold_d = pixel_i;
          state_d     = ST_MINUS;
          if (sof_i) begin
            error_d = 1'b1;
            col_d   = '0;
            row_d   = '0;
          end
        end
      end
      ST_MINUS: begin
        if (accept && sof_i) begin
          error_d     = 1'b1;
          plus_hold_d = pixel_i;
          col_d       = '0;
          row_d       = '0;
        end else if (accept) begin
          pair_valid_d = 1'b1;
          pair_last_d  = last_pos;
          pair_plus_d  = plus_hold_q;
          pair_minus_d = pixel_i;
          pair_col_d   = col_q;
          pair_row_d   = row_q;
          if (col_q == COL_MAX) begin
            col_d = '0;
            row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (!last_pos) begin
            state_d = ST_PLUS;
          end else if (FLUSH_CYCLES > 0) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) state_d = ST_IDLE;
        else flush_cnt_d = flush_cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d != ST_FLUSH);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
      plus_hold_q  <= '0;
      col_q        <= '0;
      row_q        <= '0;
      flush_cnt_q  <= '0;
      pair_valid_q <= 1'b0;
      pair_last_q  <= 1'b0;
      pair_plus_q  <= '0;
      pair_minus_q <= '0;
      pair_col_q   <= '0;
      pair_row_q   <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
      plus_hold_q  <= plus_hold_d;
      col_q        <= col_d;
      row_q        <= row_d;
      flush_cnt_q  <= flush_cnt_d;
      pair_valid_q <= pair_valid_d;
      pair_last_q  <= pair_last_d;
      pair_plus_q  <= pair_plus_d;
      pair_minus_q <= pair_minus_d;
      pair_col_q   <= pair_col_d;
      pair_row_q   <= pair_row_d;
    end
  end

  // The plus lane carries {last, col} and the minus lane carries row.
  uint_to_fp16 #(
    .PIXEL_WIDTH(PIXEL_WIDTH),
    .SIDE_WIDTH (COORD_WIDTH + 1)
  ) u_conv_plus (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .valid_i(pair_valid_q),
    .value_i(pair_plus_q),
    .side_i ({pair_last_q, pair_col_q}),
    .valid_o(plus_valid),
    .fp16_o (i_rho_plus_o),
    .side_o (plus_side)
  );

  uint_to_fp16 #(
    .PIXEL_WIDTH(PIXEL_WIDTH),
    .SIDE_WIDTH (COORD_WIDTH)
  ) u_conv_minus (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .valid_i(pair_valid_q),
    .value_i(pair_minus_q),
    .side_i (pair_row_q),
    .valid_o(minus_valid),
    .fp16_o (i_rho_minus_o),
    .side_o (row_o)
  );

  assign col_o         = plus_side[COORD_WIDTH-1:0];
  assign valid_o       = plus_valid && minus_valid;
  assign frame_done_o  = valid_o && plus_side[COORD_WIDTH];
  assign pixel_ready_o = ready_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_dfdd_input_formatter.sv
// Directed bench for dfdd_input_formatter on a 4x4 frame with FLUSH_CYCLES=3.
// Expected FP16 codes are hand-computed; DFDD_INPUT_NORMALIZE_EN shifts exponents by 8.
module tb_dfdd_input_formatter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  pixel_i = '0;
  logic        pixel_valid_i = 1'b0;
  logic        pixel_ready_o;
  logic        sof_i = 1'b0;
  logic [15:0] i_rho_plus_o, i_rho_minus_o, col_o, row_o;
  logic        valid_o, frame_done_o, error_o;

`ifdef DFDD_INPUT_NORMALIZE_EN
  localparam logic [15:0] NORM_ADJ = 16'h2000;
`else
  localparam logic [15:0] NORM_ADJ = 16'h0000;
`endif

  typedef struct {
    logic [15:0] p;
    logic [15:0] m;
    logic [15:0] col;
    logic [15:0] row;
    logic        done;
    int          cyc;
  } strobe_t;

  strobe_t    q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] tbl [10] = '{8'd1, 8'd0, 8'd2, 8'd255, 8'd128, 8'd3, 8'd5, 8'd7, 8'd64, 8'd200};
  int         acc_a [16];

  dfdd_input_formatter #(
    .IMAGE_WIDTH (4),
    .IMAGE_HEIGHT(4),
    .PIXEL_WIDTH (8),
    .FLUSH_CYCLES(3)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pixel_i      (pixel_i),
    .pixel_valid_i(pixel_valid_i),
    .pixel_ready_o(pixel_ready_o),
    .sof_i        (sof_i),
    .i_rho_plus_o (i_rho_plus_o),
    .i_rho_minus_o(i_rho_minus_o),
    .col_o        (col_o),
    .row_o        (row_o),
    .valid_o      (valid_o),
    .frame_done_o (frame_done_o),
    .error_o      (error_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (valid_o) q.push_back('{i_rho_plus_o, i_rho_minus_o, col_o, row_o, frame_done_o, cyc});
  end

  function automatic logic [15:0] fp16_of(input logic [7:0] v);
    logic [15:0] r;
    case (v)
      8'd0:    r = 16'h0000;
      8'd1:    r = 16'h3C00;
      8'd2:    r = 16'h4000;
      8'd3:    r = 16'h4200;
      8'd5:    r = 16'h4500;
      8'd7:    r = 16'h4700;
      8'd64:   r = 16'h5400;
      8'd128:  r = 16'h5800;
      8'd200:  r = 16'h5A40;
      8'd255:  r = 16'h5BF8;
      default: r = 16'hxxxx;
    endcase
    if (v != 8'd0) r = r - NORM_ADJ;
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents one beat from a negedge and returns the cycle index of the accepting edge.
  task automatic apply_stimulus(input logic [7:0] pix, input logic sof, output int acc);
    logic was_ready;
    int   tries;
    tries = 0;
    acc = -1;
    pixel_i = pix;
    sof_i = sof;
    pixel_valid_i = 1'b1;
    while (acc < 0 && tries < 100) begin
      was_ready = pixel_ready_o;
      @(negedge clk_i);
      if (was_ready) acc = cyc;
      tries++;
    end
    pixel_valid_i = 1'b0;
    sof_i = 1'b0;
    check_output("beat_accepted", (acc >= 0), 1);
  endtask

  task automatic check_pair(input string tag, input logic [7:0] pv, input logic [7:0] mv,
                            input int col, input int row, input logic done, input int exp_cyc);
    strobe_t s;
    int waited;
    waited = 0;
    while (q.size() == 0 && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    check_output({tag, "_present"}, (q.size() != 0), 1);
    if (q.size() != 0) begin
      s = q.pop_front();
      check_output({tag, "_plus"},  s.p, fp16_of(pv));
      check_output({tag, "_minus"}, s.m, fp16_of(mv));
      check_output({tag, "_col"},   s.col, col);
      check_output({tag, "_row"},   s.row, row);
      check_output({tag, "_done"},  s.done, done);
      check_output({tag, "_lat"},   s.cyc, exp_cyc);
    end
  endtask

  initial begin
    int a0, a1, a2, dummy;

    // Reset state
    repeat (2) @(negedge clk_i);
    check_output("rst_ready", pixel_ready_o, 0);
    check_output("rst_valid", valid_o, 0);
    check_output("rst_plus", i_rho_plus_o, 0);
    check_output("rst_minus", i_rho_minus_o, 0);
    check_output("rst_error", error_o, 0);
    check_output("rst_done", frame_done_o, 0);
    rst_i = 1'b0;
    check_output("rel_ready_low", pixel_ready_o, 0);
    @(negedge clk_i);
    check_output("rel_ready_high", pixel_ready_o, 1);

    // Beats before sof are dropped
    apply_stimulus(8'd255, 1'b0, dummy);
    apply_stimulus(8'd1, 1'b0, dummy);
    repeat (4) @(negedge clk_i);
    check_output("presof_none", q.size(), 0);

    // Full 4x4 frame with valid gaps, then the flush hold-off
    $display("[TB] frame A");
    for (int k = 0; k < 16; k++) begin
      apply_stimulus(tbl[k % 10], (k == 0), dummy);
      if (k == 3 || k == 9) @(negedge clk_i);
      apply_stimulus(tbl[(k + 3) % 10], 1'b0, acc_a[k]);
      if (k == 6) repeat (2) @(negedge clk_i);
    end
    check_output("flush_ready_c0", pixel_ready_o, 0);
    @(negedge clk_i);
    check_output("flush_ready_c1", pixel_ready_o, 0);
    @(negedge clk_i);
    check_output("flush_ready_c2", pixel_ready_o, 0);
    @(negedge clk_i);
    check_output("flush_ready_c3", pixel_ready_o, 1);
    for (int k = 0; k < 16; k++) begin
      check_pair($sformatf("A%0d", k), tbl[k % 10], tbl[(k + 3) % 10], k % 4, k / 4, (k == 15), acc_a[k] + 2);
    end
    check_output("A_extra", q.size(), 0);

    // Next frame restarts at (0,0); sof on a minus beat flags an error and restarts
    $display("[TB] frame B");
    apply_stimulus(8'd2, 1'b1, dummy);
    apply_stimulus(8'd3, 1'b0, a0);
    apply_stimulus(8'd5, 1'b0, dummy);
    apply_stimulus(8'd7, 1'b0, a1);
    check_output("err_clear", error_o, 0);
    apply_stimulus(8'd64, 1'b0, dummy);
    apply_stimulus(8'd200, 1'b1, dummy);
    check_output("err_set", error_o, 1);
    apply_stimulus(8'd1, 1'b0, a2);
    check_pair("B0", 8'd2, 8'd3, 0, 0, 1'b0, a0 + 2);
    check_pair("B1", 8'd5, 8'd7, 1, 0, 1'b0, a1 + 2);
    check_pair("B_restart", 8'd200, 8'd1, 0, 0, 1'b0, a2 + 2);
    check_output("err_sticky", error_o, 1);

    // Reset with a pair in flight and a plus pixel held
    $display("[TB] mid-frame reset");
    apply_stimulus(8'd255, 1'b0, dummy);
    apply_stimulus(8'd128, 1'b0, dummy);
    apply_stimulus(8'd64, 1'b0, dummy);
    rst_i = 1'b1;
    #1;
    check_output("mrst_plus", i_rho_plus_o, 0);
    check_output("mrst_minus", i_rho_minus_o, 0);
    check_output("mrst_error", error_o, 0);
    check_output("mrst_ready", pixel_ready_o, 0);
    check_output("mrst_valid", valid_o, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_output("mrst_ready_back", pixel_ready_o, 1);
    repeat (4) @(negedge clk_i);
    check_output("mrst_no_stale", q.size(), 0);
    apply_stimulus(8'd7, 1'b0, dummy);
    repeat (3) @(negedge clk_i);
    check_output("mrst_drop", q.size(), 0);
    apply_stimulus(8'd128, 1'b1, dummy);
    apply_stimulus(8'd0, 1'b0, a0);
    check_pair("C0", 8'd128, 8'd0, 0, 0, 1'b0, a0 + 2);
    check_output("C_error", error_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
